// File: rtl/key_press_classifier_if.sv
// Key classifier bus: debounced key level in, press pulses and hold time out.
// slave = classifier side, master = key source / application side.
interface key_press_classifier_if;
  logic       key_lvl;
  logic       short_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       key_held;
  logic [9:0] hold_ms;

  modport master (
    output key_lvl,
    input  short_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  key_held,
    input  hold_ms
  );

  modport slave (
    input  key_lvl,
    output short_pulse,
    output long_pulse,
    output repeat_pulse,
    output key_held,
    output hold_ms
  );
endinterface

// File: rtl/key_press_classifier.sv
// Classifies debounced key presses into short / long / auto-repeat pulses.
// Ports: clk, rst (async, active-high), bus (slave: key_lvl in; pulses, key_held, hold_ms out).
module key_press_classifier #(
  parameter int CLK_PER_MS = 20000,
  parameter int LONG_MS    = 500,
  parameter int REPEAT_MS  = 100,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  key_press_classifier_if.slave bus
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_MS - 1);
  localparam logic [9:0]    LONG_M1 = 10'(LONG_MS - 1);
  localparam logic [9:0]    REP_M1  = 10'(REPEAT_MS - 1);
  localparam logic [9:0]    SAT     = 10'h3ff;
  localparam logic          POL     = 1'(ACTIVE_LOW);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    HOLD
  } state_t;

  state_t          state;
  logic            key_q;
  logic            key_q_d;
  logic [PW-1:0]   pre_cnt;
  logic [9:0]      hold_q;
  logic [9:0]      rep_cnt;
  logic            held_q;
  logic            short_q;
  logic            long_q;
  logic            rep_q;

  logic press_edge;
  logic tick;

  assign press_edge = key_q & ~key_q_d;
  assign tick       = held_q & (pre_cnt == PRE_MAX);

  // key_q/key_q_d reset to "pressed" so a key held through reset
  // produces no press edge until it has been released once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= 1'b1;
      key_q_d <= 1'b1;
      state   <= IDLE;
      pre_cnt <= '0;
      hold_q  <= '0;
      rep_cnt <= '0;
      held_q  <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      key_q   <= bus.key_lvl ^ POL;
      key_q_d <= key_q;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;

      if (held_q) begin
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      end

      // A release seen in the same cycle as a tick takes priority:
      // the tick is dropped, so hold_ms and rep_cnt stay put.
      unique case (state)
        IDLE: begin
          if (press_edge) begin
            state   <= PRESS;
            held_q  <= 1'b1;
            pre_cnt <= '0;
            hold_q  <= '0;
          end
        end
        PRESS: begin
          if (!key_q) begin
            state   <= IDLE;
            held_q  <= 1'b0;
            short_q <= 1'b1;
          end else if (tick) begin
            hold_q <= (hold_q == SAT) ? hold_q : hold_q + 1'b1;
            if (hold_q == LONG_M1) begin
              state   <= HOLD;
              long_q  <= 1'b1;
              rep_cnt <= '0;
            end
          end
        end
        HOLD: begin
          if (!key_q) begin
            state  <= IDLE;
            held_q <= 1'b0;
          end else if (tick) begin
            hold_q <= (hold_q == SAT) ? hold_q : hold_q + 1'b1;
            if (rep_cnt == REP_M1) begin
              rep_cnt <= '0;
              rep_q   <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          held_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.short_pulse  = short_q;
  assign bus.long_pulse   = long_q;
  assign bus.repeat_pulse = rep_q;
  assign bus.key_held     = held_q;
  assign bus.hold_ms      = hold_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// Randomised bench for key_press_classifier against a per-press model.
// Two instances: active-low key, and active-high key driven with the inverse level.
module tb_key_press_classifier;

  localparam int CPM  = 20;
  localparam int LONG = 5;
  localparam int REP  = 2;

  logic clk;
  logic rst;
  int   cyc;

  int n_vec;
  int n_bad;

  int a_short, a_long, a_rep, a_multi;
  int b_short, b_long, b_rep;
  int short_cyc, long_cyc;

  key_press_classifier_if bus_a ();
  key_press_classifier_if bus_b ();

  assign bus_b.key_lvl = ~bus_a.key_lvl;

  key_press_classifier #(
    .CLK_PER_MS (CPM),
    .LONG_MS    (LONG),
    .REPEAT_MS  (REP),
    .ACTIVE_LOW (1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  key_press_classifier #(
    .CLK_PER_MS (CPM),
    .LONG_MS    (LONG),
    .REPEAT_MS  (REP),
    .ACTIVE_LOW (0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.short_pulse) begin
        a_short++;
        short_cyc = cyc;
      end
      if (bus_a.long_pulse) begin
        a_long++;
        long_cyc = cyc;
      end
      if (bus_a.repeat_pulse) a_rep++;
      if (int'(bus_a.short_pulse) + int'(bus_a.long_pulse)
          + int'(bus_a.repeat_pulse) > 1) a_multi++;
      if (bus_b.short_pulse)  b_short++;
      if (bus_b.long_pulse)   b_long++;
      if (bus_b.repeat_pulse) b_rep++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    a_short = 0; a_long = 0; a_rep = 0; a_multi = 0;
    b_short = 0; b_long = 0; b_rep = 0;
    short_cyc = -1; long_cyc = -1;
  endtask

  // Key pressed for len clocks: the press counts one ms per full CPM
  // clocks it survives after entering PRESS; the release cycle never counts.
  task automatic model(input int len, output int e_short, output int e_long,
                       output int e_rep, output int e_hold);
    int ticks;
    ticks   = (len - 1) / CPM;
    e_short = (ticks < LONG) ? 1 : 0;
    e_long  = (ticks >= LONG) ? 1 : 0;
    e_rep   = (ticks >= LONG) ? (ticks - LONG) / REP : 0;
    e_hold  = (ticks > 1023) ? 1023 : ticks;
  endtask

  task automatic press(input int len, input string tag);
    int p, es, el, er, eh;
    clr();
    p = cyc;
    bus_a.key_lvl = 1'b0;
    repeat (len) @(posedge clk);
    #1;
    bus_a.key_lvl = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".held_on"}, int'(bus_a.key_held), 1);
    @(posedge clk);
    #1;
    chk({tag, ".held_off"}, int'(bus_a.key_held), 0);
    repeat (3) @(posedge clk);
    #1;
    model(len, es, el, er, eh);
    chk({tag, ".short"}, a_short, es);
    chk({tag, ".long"}, a_long, el);
    chk({tag, ".rep"}, a_rep, er);
    chk({tag, ".hold"}, int'(bus_a.hold_ms), eh);
    chk({tag, ".onehot"}, a_multi, 0);
    chk({tag, ".b_short"}, b_short, es);
    chk({tag, ".b_long"}, b_long, el);
    chk({tag, ".b_rep"}, b_rep, er);
    chk({tag, ".b_hold"}, int'(bus_b.hold_ms), eh);
    if (es != 0) chk({tag, ".short_at"}, short_cyc, p + len + 2);
    else         chk({tag, ".long_at"}, long_cyc, p + 2 + CPM * LONG);
    repeat ($urandom_range(8, 2)) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".short"}, int'(bus_a.short_pulse), 0);
    chk({tag, ".long"}, int'(bus_a.long_pulse), 0);
    chk({tag, ".rep"}, int'(bus_a.repeat_pulse), 0);
    chk({tag, ".held"}, int'(bus_a.key_held), 0);
    chk({tag, ".hold"}, int'(bus_a.hold_ms), 0);
    chk({tag, ".b_held"}, int'(bus_b.key_held), 0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    clr();
    rst = 1'b1;
    bus_a.key_lvl = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk_zero("post_rst");

    press(70, "short3ms");
    press(210, "long10ms");
    press(100, "tie");
    press(101, "just_long");
    press(1, "glitch");

    // Reset while a press is in progress, key kept down afterwards.
    bus_a.key_lvl = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    repeat (150) @(posedge clk);
    #1;
    chk("rst_held.pulses", a_short + a_long + a_rep, 0);
    chk("rst_held.b_pulses", b_short + b_long + b_rep, 0);
    chk("rst_held.key_held", int'(bus_a.key_held), 0);
    bus_a.key_lvl = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    press(30, "re_press");

    for (int i = 0; i < 14; i++) begin
      int k, len;
      k = $urandom_range(2, 0);
      if (k == 0)      len = $urandom_range(99, 1);
      else if (k == 1) len = $urandom_range(105, 95);
      else             len = $urandom_range(400, 101);
      press(len, $sformatf("rnd%0d_len%0d", i, len));
    end

    press(22000, "sat");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
